sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency SRAM macro (512 x 104, 8 write-mask lanes of 13 bits) between two requesters, A and B.
- Round-robin grant, at most one access per cycle.
- Returns read data to the requester that issued the read.
- Optional power-on zero-fill sweep.
- Sits between the pipeline clients and the RW0 port of the macro.

Parameters:
- ADDR_W, 9, SRAM address width
- DEPTH, 512, number of SRAM entries; must equal 2**ADDR_W
- DATA_W, 104, SRAM word width
- MASK_W, 8, write-mask lanes; each lane is DATA_W/MASK_W = 13 bits

Ports:
- clock  in  1  single clock for all logic and the macro
- reset_n  in  1  asynchronous, active-low reset
- a_req_valid  in  1  requester A request valid
- a_req_ready  out  1  A request accepted this cycle
- a_req_wmode  in  1  1 = write, 0 = read
- a_req_addr  in  ADDR_W  A address
- a_req_wmask  in  MASK_W  A lane write mask (ignored on read)
- a_req_wdata  in  DATA_W  A write data
- a_resp_valid  out  1  A read data valid, one-cycle pulse
- a_resp_rdata  out  DATA_W  A read data
- b_req_* / b_resp_*  as A  requester B, identical widths and meaning
- sram_en  out  1  macro RW0 enable
- sram_wmode  out  1  macro RW0 write mode
- sram_addr  out  ADDR_W  macro RW0 address
- sram_wmask  out  MASK_W  macro RW0 write mask
- sram_wdata  out  DATA_W  macro RW0 write data
- sram_rdata  in  DATA_W  macro RW0 read data, valid the cycle after a read enable
- init_done  out  1  high once the block accepts requests

Behaviour:
- Reset (async assert, sync release). Every output and register goes to its reset value:
  - state = INIT (or RUN without the feature), init counter = 0, rr_last = B
  - resp pending = 0, a/b_resp_valid = 0, resp_rdata registers = 0
  - init_done = 0 (or 1 without the feature)
  - ready outputs and all sram_* outputs are combinational and evaluate to 0 while reset_n = 0
- States: INIT, RUN. There is no return to INIT except via reset.
- INIT:
  - Each cycle drives sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter; counter increments.
  - Exactly DEPTH write cycles. When counter = DEPTH-1 is written, next state = RUN.
  - a_req_ready = b_req_ready = 0 throughout.
- init_done = 1 in RUN. It rises on the cycle after the last sweep write.
- RUN arbitration (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester that is not rr_last.
  - x_req_ready = (state==RUN) && grant==x. Ready may depend on valid. A requester must hold its request stable until ready.
- On grant:
  - sram_en=1; sram_wmode, addr, wmask and wdata come from the granted requester, passed straight through combinationally with no added latency.
  - rr_last <= granted requester.
  - No grant -> sram_en=0 and all other sram_* = 0.
- Reads:
  - An accepted read registers pending=1 and owner.
  - Next cycle: owner_resp_valid=1 and owner_resp_rdata = sram_rdata. Fixed latency 1 cycle.
  - The non-owner's resp_valid stays 0 and its rdata holds its last value.
  - There is no response backpressure; requesters must sink the response.
- Writes produce no response.
- Back-to-back accesses:
  - Read-after-write to the same address on consecutive cycles returns the new data; the macro commits the write before the next read.
  - A read issued one cycle after another read is legal every cycle: full throughput, one access per cycle.
- Reset asserted mid-operation: pending responses are dropped (no resp_valid is emitted) and an INIT sweep in progress restarts from address 0.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN
- Defined:
  - Reset state is INIT and the DEPTH-cycle zero-fill sweep runs as above.
  - init_done goes high DEPTH cycles after reset release.
- Undefined:
  - The INIT state and init counter are not built. Reset state is RUN.
  - init_done is tied to 1 (it reads 0 only while reset_n=0).
  - Requests may be accepted in the first cycle after reset release.
  - SRAM contents are undefined until written.

Test Plan:
- Init sweep (INIT_EN defined): release reset, hold a_req_valid=1 -> a_req_ready=0 for 512 cycles; sram_addr walks 0..511 with wmask=0xFF and wdata=0; init_done=1 on cycle 513. A then reads address 0x1A5 -> a_resp_valid the next cycle with rdata=0.
- Masked write/read: A writes addr 0x010, mask 0x81, data all-ones; A reads 0x010 -> rdata has lanes 0 and 7 all-ones and lanes 1-6 zero (after init), latency exactly 1.
- Round-robin: A and B both hold reads continuously to 0x001/0x002 -> grants alternate A,B,A,B starting with A; each resp_valid pulses only for its owner with the correct data.
- Read-after-write: B writes 0x1FF with data 0x0123..., mask 0xFF; the next cycle A reads 0x1FF -> A gets the new data the following cycle; b_resp_valid stays 0.
- Async reset mid-read: A read accepted, reset_n dropped before the next clock edge -> a_resp_valid never pulses and all outputs are 0 during reset; the INIT sweep restarts from address 0 (INIT_EN).
- Without INIT_EN: A read request on the first cycle after reset release -> a_req_ready=1 immediately and init_done=1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, 1-cycle-latency SRAM macro.
// Optional power-on zero-fill sweep is built when SRAM_ARB_INIT_EN is defined.
`timescale 1ns/1ps
module sram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 104,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wmode,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [MASK_W-1:0] a_req_wmask,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_resp_valid,
    output logic [DATA_W-1:0] a_resp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_wmode,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [MASK_W-1:0] b_req_wmask,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_resp_valid,
    output logic [DATA_W-1:0] b_resp_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("sram_port_arbiter: DEPTH must equal 2**ADDR_W");
    end

    logic run;
    logic grant_a;
    logic grant_b;
    logic rr_last;
    logic pending;
    logic owner;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

`ifdef SRAM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] init_cnt_next;
    logic              sweep;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    // The sweep writes every address exactly once, then hands over to RUN for good.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        if (state == ST_INIT) begin
            init_cnt_next = init_cnt + 1'b1;
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    assign sweep = reset_n && (state == ST_INIT);
    assign run   = reset_n && (state == ST_RUN);
`else
    assign run = reset_n;
`endif

    assign init_done = run;

    // On a tie the requester that was not served last wins.
    assign grant_a = run && a_req_valid && (!b_req_valid || (rr_last == OWN_B));
    assign grant_b = run && b_req_valid && (!a_req_valid || (rr_last == OWN_A));

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
`ifdef SRAM_ARB_INIT_EN
        if (sweep) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt;
            sram_wmask = '1;
            sram_wdata = '0;
        end else
`endif
        if (grant_a) begin
            sram_en    = 1'b1;
            sram_wmode = a_req_wmode;
            sram_addr  = a_req_addr;
            sram_wmask = a_req_wmask;
            sram_wdata = a_req_wdata;
        end else if (grant_b) begin
            sram_en    = 1'b1;
            sram_wmode = b_req_wmode;
            sram_addr  = b_req_addr;
            sram_wmask = b_req_wmask;
            sram_wdata = b_req_wdata;
        end
    end

    // Track who was served last and which requester owns the read in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last   <= OWN_B;
            pending   <= 1'b0;
            owner     <= OWN_A;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (grant_a) begin
                rr_last <= OWN_A;
            end else if (grant_b) begin
                rr_last <= OWN_B;
            end
            pending <= (grant_a && !a_req_wmode) || (grant_b && !b_req_wmode);
            owner   <= grant_b ? OWN_B : OWN_A;
            if (a_resp_valid) begin
                a_rdata_q <= sram_rdata;
            end
            if (b_resp_valid) begin
                b_rdata_q <= sram_rdata;
            end
        end
    end

    // Macro data is forwarded in the response cycle; the register keeps it afterwards.
    assign a_resp_valid = pending && (owner == OWN_A);
    assign b_resp_valid = pending && (owner == OWN_B);
    assign a_resp_rdata = a_resp_valid ? sram_rdata : a_rdata_q;
    assign b_resp_rdata = b_resp_valid ? sram_rdata : b_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 512x104 masked SRAM macro.
// Sweep checks are compiled in when SRAM_ARB_INIT_EN is defined.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
    localparam int DATA_W = 104;
    localparam int MASK_W = 8;
    localparam int LANE_W = DATA_W / MASK_W;

    localparam logic [DATA_W-1:0] D_RAW  = 104'h0123456789ABCDEF0123456789;
    localparam logic [DATA_W-1:0] P1     = {13{8'hA5}};
    localparam logic [DATA_W-1:0] P2     = {13{8'h3C}};
    localparam logic [DATA_W-1:0] MASKED = {13'h1FFF, 78'd0, 13'h1FFF};

    logic              clock = 1'b0;
    logic              reset_n;
    logic              a_req_valid, a_req_ready, a_req_wmode;
    logic [ADDR_W-1:0] a_req_addr;
    logic [MASK_W-1:0] a_req_wmask;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_resp_valid;
    logic [DATA_W-1:0] a_resp_rdata;
    logic              b_req_valid, b_req_ready, b_req_wmode;
    logic [ADDR_W-1:0] b_req_addr;
    logic [MASK_W-1:0] b_req_wmask;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_resp_valid;
    logic [DATA_W-1:0] b_resp_rdata;
    logic              sram_en, sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              init_done;

    logic [DATA_W-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wmode(a_req_wmode),
        .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wmode(b_req_wmode),
        .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // Macro model: masked write commits at the edge, read data appears one cycle later.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic aw, input logic [ADDR_W-1:0] aa,
                                 input logic [MASK_W-1:0] am, input logic [DATA_W-1:0] ad,
                                 input logic bv, input logic bw, input logic [ADDR_W-1:0] ba,
                                 input logic [MASK_W-1:0] bm, input logic [DATA_W-1:0] bd);
        a_req_valid = av; a_req_wmode = aw; a_req_addr = aa; a_req_wmask = am; a_req_wdata = ad;
        b_req_valid = bv; b_req_wmode = bw; b_req_addr = ba; b_req_wmask = bm; b_req_wdata = bd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        sram_rdata = '0;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 9'h1A5, 8'h00, '0, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_a_ready", a_req_ready, 1'b0);
        checkOutput("rst_sram_en", sram_en, 1'b0);
        checkOutput("rst_sram_addr", sram_addr, '0);
        checkOutput("rst_init_done", init_done, 1'b0);
        checkOutput("rst_a_resp_valid", a_resp_valid, 1'b0);
        checkOutput("rst_a_resp_rdata", a_resp_rdata, '0);
        next_cycle();
        reset_n = 1'b1;

`ifdef SRAM_ARB_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            checkOutput("sweep_a_ready", a_req_ready, 1'b0);
            checkOutput("sweep_addr", sram_addr, ADDR_W'(i));
            checkOutput("sweep_en_wmode_mask", {sram_en, sram_wmode, sram_wmask}, 10'h3FF);
            checkOutput("sweep_wdata", sram_wdata, '0);
            checkOutput("sweep_init_done", init_done, 1'b0);
            next_cycle();
        end
`endif
        // A reads 0x1A5 as soon as the block accepts requests.
        @(negedge clock);
        checkOutput("first_a_ready", a_req_ready, 1'b1);
        checkOutput("first_init_done", init_done, 1'b1);
        checkOutput("first_sram_addr", sram_addr, 9'h1A5);
        checkOutput("first_sram_en_wmode", {sram_en, sram_wmode}, 2'b10);
        checkOutput("first_b_ready", b_req_ready, 1'b0);
        next_cycle();
        // A masked write to 0x010 while the read data returns.
        applyStimulus(1'b1, 1'b1, 9'h010, 8'h81, '1, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("rd1a5_valid", a_resp_valid, 1'b1);
        checkOutput("rd1a5_data", a_resp_rdata, '0);
        checkOutput("rd1a5_b_valid", b_resp_valid, 1'b0);
        checkOutput("wr010_wmask", sram_wmask, 8'h81);
        checkOutput("wr010_wmode", sram_wmode, 1'b1);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 9'h010, 8'h00, '0, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("wr010_no_resp", a_resp_valid, 1'b0);
        checkOutput("rd010_ready", a_req_ready, 1'b1);
        next_cycle();
        // B writes 0x1FF; A reads it back on the very next cycle.
        applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, '0, 1'b1, 1'b1, 9'h1FF, 8'hFF, D_RAW);
        @(negedge clock);
        checkOutput("rd010_valid", a_resp_valid, 1'b1);
        checkOutput("rd010_data", a_resp_rdata, MASKED);
        checkOutput("wr1ff_b_ready", b_req_ready, 1'b1);
        checkOutput("wr1ff_addr", sram_addr, 9'h1FF);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 9'h1FF, 8'h00, '0, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("raw_a_ready", a_req_ready, 1'b1);
        checkOutput("wr1ff_b_no_resp", b_resp_valid, 1'b0);
        next_cycle();
        applyStimulus(1'b1, 1'b1, 9'h001, 8'hFF, P1, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("raw_a_valid", a_resp_valid, 1'b1);
        checkOutput("raw_a_data", a_resp_rdata, D_RAW);
        checkOutput("raw_b_valid", b_resp_valid, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, '0, 1'b1, 1'b1, 9'h002, 8'hFF, P2);
        @(negedge clock);
        checkOutput("wr002_b_ready", b_req_ready, 1'b1);
        checkOutput("wr002_a_hold", a_resp_rdata, D_RAW);
        next_cycle();
        // Both hold reads; B was served last so grants go A,B,A,B.
        applyStimulus(1'b1, 1'b0, 9'h001, 8'h00, '0, 1'b1, 1'b0, 9'h002, 8'h00, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("rr_a_ready", a_req_ready, (k % 2) == 0);
            checkOutput("rr_b_ready", b_req_ready, (k % 2) == 1);
            checkOutput("rr_sram_addr", sram_addr, ((k % 2) == 0) ? 9'h001 : 9'h002);
            checkOutput("rr_a_resp_valid", a_resp_valid, (k % 2) == 1);
            checkOutput("rr_b_resp_valid", b_resp_valid, (k == 2));
            if (k % 2 == 1) checkOutput("rr_a_data", a_resp_rdata, P1);
            if (k == 2) checkOutput("rr_b_data", b_resp_rdata, P2);
            next_cycle();
        end
        applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, '0, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("rr_last_b_valid", b_resp_valid, 1'b1);
        checkOutput("rr_last_b_data", b_resp_rdata, P2);
        checkOutput("rr_last_a_valid", a_resp_valid, 1'b0);
        checkOutput("rr_a_hold", a_resp_rdata, P1);
        checkOutput("idle_sram_en", sram_en, 1'b0);
        next_cycle();
        // Reset lands between an accepted read and its response edge.
        applyStimulus(1'b1, 1'b0, 9'h010, 8'h00, '0, 1'b0, 1'b0, 9'h000, 8'h00, '0);
        @(negedge clock);
        checkOutput("mid_a_ready", a_req_ready, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_sram_en", sram_en, 1'b0);
        checkOutput("mid_rst_a_ready", a_req_ready, 1'b0);
        checkOutput("mid_rst_init_done", init_done, 1'b0);
        checkOutput("mid_rst_a_rdata", a_resp_rdata, '0);
        checkOutput("mid_rst_b_rdata", b_resp_rdata, '0);
        next_cycle();
        checkOutput("mid_rst_a_valid", a_resp_valid, 1'b0);
        a_req_valid = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_a_valid", a_resp_valid, 1'b0);
`ifdef SRAM_ARB_INIT_EN
        checkOutput("restart_addr", sram_addr, 9'h000);
        checkOutput("restart_en", sram_en, 1'b1);
        checkOutput("restart_init_done", init_done, 1'b0);
        next_cycle();
        @(negedge clock);
        checkOutput("restart_addr1", sram_addr, 9'h001);
`else
        checkOutput("post_rst_init_done", init_done, 1'b1);
        checkOutput("post_rst_sram_en", sram_en, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
